// File: rtl/interval_timer_pkg.sv
// Shared timer constants: default board tick rate, phase durations and width helpers.
// Pure definitions; no state, no latency, no backpressure.
package interval_timer_pkg;

    localparam int TIMER_WIDTH  = 8;
    localparam int DEF_TICK_DIV = 50_000_000;

    localparam int GREEN_S = 30;
    localparam int AMBER_S = 4;
    localparam int RED_S   = 30;
    localparam int PED_S   = 15;

    typedef enum logic [1:0] {
        PH_GREEN = 2'd0,
        PH_AMBER = 2'd1,
        PH_RED   = 2'd2,
        PH_PED   = 2'd3
    } phase_e;

    function automatic int phase_seconds(phase_e ph);
        case (ph)
            PH_GREEN: return GREEN_S;
            PH_AMBER: return AMBER_S;
            PH_RED:   return RED_S;
            default:  return PED_S;
        endcase
    endfunction

    // A divide-by-1 prescaler still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle between a phase controller (master) and the interval timer (slave).
// Plain wires; timing is owned by the endpoints, no backpressure.
interface interval_timer_if
    import interval_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
);
    logic [WIDTH-1:0] value;
    logic             start_timer;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] remaining;
    logic             running;
    logic             expired;
    logic             done;

    modport master (
        output value, start_timer, pause, auto_reload,
        input  remaining, running, expired, done
    );

    modport slave (
        input  value, start_timer, pause, auto_reload,
        output remaining, running, expired, done
    );
endinterface

// File: rtl/interval_timer_tick_prescaler.sv
// Divides clkin into a one-cycle tick every TICK_DIV enabled cycles; clr restarts the phase.
// Tick is combinational off the counter; counter holds when en is low, no backpressure.
module tick_prescaler
    import interval_timer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clkin,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int            CW   = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clkin) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/interval_timer.sv
// Seconds countdown timer with pause, restart and periodic auto-reload; expired is registered.
// Expiry edge = start edge + value*TICK_DIV + paused cycles; pause is the only hold, no backpressure.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic             clkin,
    input  logic             reset,
    interval_timer_if.slave  tmr
);
    logic [WIDTH-1:0] remaining_q;
    logic             running_q;
    logic             done_q;
    logic             expired_q;

    logic tick;
    logic last_tick;
    logic reload;

    // The prescaler only advances while running, so a tick always belongs to a live interval.
    assign last_tick = tick && running_q && (remaining_q == WIDTH'(1));
    assign reload    = last_tick && tmr.auto_reload && (tmr.value != '0);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clkin (clkin),
        .reset (reset),
        .clr   (tmr.start_timer || reload),
        .en    (running_q && !tmr.pause),
        .tick  (tick)
    );

    always_ff @(posedge clkin) begin
        if (reset) begin
            remaining_q <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else if (tmr.start_timer) begin
            // A zero-length interval finishes on the load edge itself.
            remaining_q <= tmr.value;
            running_q   <= (tmr.value != '0);
            done_q      <= (tmr.value == '0);
            expired_q   <= (tmr.value == '0);
        end else begin
            expired_q <= 1'b0;
            if (last_tick) begin
                expired_q <= 1'b1;
                if (reload) begin
                    remaining_q <= tmr.value;
                end else begin
                    remaining_q <= '0;
                    running_q   <= 1'b0;
                    done_q      <= 1'b1;
                end
            end else if (tick && (remaining_q != '0)) begin
                remaining_q <= remaining_q - WIDTH'(1);
            end
        end
    end

    assign tmr.remaining = remaining_q;
    assign tmr.running   = running_q;
    assign tmr.done      = done_q;
    assign tmr.expired   = expired_q;
endmodule
